// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU data-memory controller: BRAM loads, sub-word read-modify-write, misalignment flag
// Optional memory-mapped LED register enabled by DATA_MEM_MMIO_LED_EN.
module data_mem_ctrl #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] LED_ADDR = 32'h0000_2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [3:0]        sign_mask_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              err_o,
    output logic [7:0]        led_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [31:0]       bram_wdata_o,
    output logic              bram_we_o,
    input  logic [31:0]       bram_rdata_i
);

    typedef enum logic [1:0] {IDLE, LOAD, RMW} state_t;

    state_t      state_q, state_d;
    logic        done_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        stall_c, we_c;
    logic [31:0] wdata_c;

    logic        is_word, is_half, misaligned, led_hit, is_led, accept;
    logic [31:0] src_word, byte_shift, load_val, merged;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign is_word    = sign_mask_i[2];
    assign is_half    = sign_mask_i[1] & ~sign_mask_i[2];
    assign misaligned = (is_word && addr_i[1:0] != 2'b00) || (is_half && addr_i[0]);
    assign led_hit    = (addr_i[31:2] == LED_ADDR[31:2]);

`ifdef DATA_MEM_MMIO_LED_EN
    logic [7:0] led_q;

    assign is_led = led_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= 8'h00;
        end else if (accept && !misaligned && memwrite_i && is_led) begin
            led_q <= wdata_i[7:0];
        end
    end

    assign led_o = led_q;

    logic unused_bits;
    assign unused_bits = sign_mask_i[0];
`else
    assign is_led = 1'b0;
    assign led_o  = 8'h00;

    logic unused_bits;
    assign unused_bits = ^{sign_mask_i[0], led_hit, addr_i[31:ADDR_W+2]};
`endif

    // done_q marks the cycle after LOAD/RMW, where the CPU still presents the finished request
    assign accept = (state_q == IDLE) && !done_q && (memread_i || memwrite_i);

    // Load lane extraction; LED loads take the same path so latency matches BRAM
    assign src_word   = is_led ? {24'h0, led_o} : bram_rdata_i;
    assign byte_shift = src_word >> {addr_i[1:0], 3'b000};
    assign byte_val   = byte_shift[7:0];
    assign half_val   = addr_i[1] ? src_word[31:16] : src_word[15:0];

    always_comb begin
        load_val = src_word;
        if (is_half) begin
            load_val = {{16{sign_mask_i[3] & half_val[15]}}, half_val};
        end else if (!is_word) begin
            load_val = {{24{sign_mask_i[3] & byte_val[7]}}, byte_val};
        end
    end

    always_comb begin
        merged = bram_rdata_i;
        if (is_half) begin
            if (addr_i[1]) begin
                merged[31:16] = wdata_i[15:0];
            end else begin
                merged[15:0] = wdata_i[15:0];
            end
        end else begin
            merged[{addr_i[1:0], 3'b000} +: 8] = wdata_i[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        we_c    = 1'b0;
        wdata_c = wdata_i;
        case (state_q)
            IDLE: begin
                if (accept && !misaligned) begin
                    if (memwrite_i) begin
                        if (is_led) begin
                            state_d = IDLE;
                        end else if (is_word) begin
                            we_c = 1'b1;
                        end else begin
                            state_d = RMW;
                            stall_c = 1'b1;
                        end
                    end else begin
                        state_d = LOAD;
                        stall_c = 1'b1;
                    end
                end
            end
            LOAD: begin
                stall_c = 1'b1;
                state_d = IDLE;
            end
            RMW: begin
                stall_c = 1'b1;
                we_c    = !is_led;
                wdata_c = merged;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q != IDLE);
            if (accept && misaligned) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b1;
            end else if (state_q == LOAD) begin
                rdata_q <= load_val;
            end
        end
    end

    // Gating with rst keeps the outputs quiet and prevents a write while an operation is aborted
    assign stall_o      = stall_c & ~rst;
    assign bram_we_o    = we_c & ~rst;
    assign bram_wdata_o = wdata_c;
    assign bram_addr_o  = addr_i[ADDR_W+1:2];
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning BRAM word-address width (2^ADDR_W 32-bit words).
REQ-002 The block SHALL have parameter LED_ADDR, default 32'h0000_2000, meaning the byte address of the memory-mapped LED register.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port addr_i, input, 32, CPU byte address.
REQ-006 The block SHALL have port wdata_i, input, 32, CPU store data, right-aligned.
REQ-007 The block SHALL have port memread_i, input, 1, load request.
REQ-008 The block SHALL have port memwrite_i, input, 1, store request.
REQ-009 The block SHALL have port sign_mask_i, input, 4, encoded as {signed, mask[2:0]}: mask 001 byte, 011 half, 111 word; signed=1 sign-extends loads.
REQ-010 The block SHALL have port rdata_o, output, 32, registered load result.
REQ-011 The block SHALL have port stall_o, output, 1, high while the request is incomplete; CPU holds inputs stable while high.
REQ-012 The block SHALL have port err_o, output, 1, sticky misalignment flag.
REQ-013 The block SHALL have port led_o, output, 8, LED register contents.
REQ-014 The block SHALL have ports bram_addr_o (output, ADDR_W), bram_wdata_o (output, 32), bram_we_o (output, 1), bram_rdata_i (input, 32), for a synchronous BRAM with read data one cycle after address.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RMW; a request is accepted in IDLE when memread_i or memwrite_i is high.
REQ-016 bram_addr_o SHALL equal addr_i[ADDR_W+1:2] during acceptance; higher address bits are ignored except for LED decode.
REQ-017 When both memread_i and memwrite_i are high, the store SHALL take priority and the load SHALL be ignored.
REQ-018 Load: IDLE->LOAD; stall_o high in the acceptance cycle; in LOAD, the selected lane is extracted, extended and registered into rdata_o; return to IDLE; rdata_o is valid and stall_o low in the cycle after LOAD.
REQ-019 Lane selection is little-endian: byte k = word[8k+7:8k] with k=addr_i[1:0]; half j = word[16j+15:16j] with j=addr_i[1].
REQ-020 Zero- or sign-extension to 32 bits SHALL follow sign_mask_i[3]; word loads are unaffected.
REQ-021 Word store: bram_we_o=1 with bram_wdata_o=wdata_i in the acceptance cycle; no stall; stays in IDLE.
REQ-022 Sub-word store: IDLE->RMW with stall_o high in the acceptance cycle; in RMW, only the addressed lanes of bram_rdata_i are replaced by wdata_i low bits; the merged word is written with bram_we_o=1; return to IDLE.
REQ-023 A misaligned access (half with addr_i[0]=1, word with addr_i[1:0]!=0) SHALL complete in the acceptance cycle with no stall and no write; rdata_o SHALL become 0 and err_o SHALL set.
REQ-024 bram_we_o SHALL be high only in the cycles defined in REQ-021 and REQ-022.
REQ-025 rdata_o SHALL hold its value until the next completed load.

Reset
REQ-026 On rst: the state SHALL be IDLE, and rdata_o=0, stall_o=0, err_o=0, led_o=0, bram_we_o=0.
REQ-027 Reset asserted mid-LOAD or mid-RMW SHALL abort the operation without a BRAM write.
REQ-028 err_o SHALL clear only on rst.

Configuration
REQ-029 With DATA_MEM_MMIO_LED_EN defined: an access whose addr_i[31:2] matches LED_ADDR[31:2] SHALL target an 8-bit LED register, not BRAM.
REQ-030 With DATA_MEM_MMIO_LED_EN defined: a store of any width to the LED register SHALL write wdata_i[7:0] in one cycle with no stall.
REQ-031 With DATA_MEM_MMIO_LED_EN defined: a load from the LED register SHALL return {24'b0, led_o} with load latency unchanged.
REQ-032 Without DATA_MEM_MMIO_LED_EN: led_o SHALL be tied to 0 and all addresses SHALL go to BRAM.

Verification
REQ-033 The bench SHALL check: word store 0xDEADBEEF at addr 0x10, then signed byte load at 0x13 -> rdata_o=0xFFFFFFDE two cycles after acceptance, with stall_o high for 2 cycles.
REQ-034 The bench SHALL check: with word 0x11223344 at 0x20, a half store 0xABCD at 0x22 -> BRAM word 0xABCD3344, with bram_we_o high only in the RMW cycle.
REQ-035 The bench SHALL check: an unsigned half load at 0x22 of 0xABCD3344 -> rdata_o=0x0000ABCD; the signed half load -> 0xFFFFABCD.
REQ-036 The bench SHALL check: a word store at 0x21 -> no write, err_o=1 and stays 1 through later valid accesses until rst.
REQ-037 The bench SHALL check: rst pulsed during the RMW cycle of a byte store -> the BRAM word is unchanged and the block is IDLE.
REQ-038 The bench SHALL check: with DATA_MEM_MMIO_LED_EN, a byte store 0x5A to 0x2000 -> led_o=0x5A next cycle; a load from 0x2000 -> 0x0000005A.
